// File: rtl/fifo_param_sync.sv
// fifo_param_sync: parametrised single-clock synchronous FIFO.
//
// Purpose
//   Buffers FIFO_DEPTH words of FIFO_WIDTH bits between a producer and a
//   consumer that share clk. It provides programmable almost-full and
//   almost-empty thresholds and an occupancy count. Reads are either
//   registered (FWFT=0) or first-word-fall-through (FWFT=1).
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   data_in      in   write data
//   wr_en        in   write request
//   rd_en        in   read request
//   data_out     out  read data (registered or fall-through, see FWFT)
//   wr_ack       out  previous-cycle write accepted
//   overflow     out  previous-cycle write rejected (FIFO was full)
//   underflow    out  previous-cycle read rejected (FIFO was empty)
//   count        out  current occupancy
//   full         out  count == FIFO_DEPTH
//   almostfull   out  count >= AF_THRESH and not full
//   half_full    out  count >= FIFO_DEPTH/2
//   almostempty  out  count <= AE_THRESH and not empty
//   empty        out  count == 0
module fifo_param_sync #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          wr_ack,
    output logic                          overflow,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          almostfull,
    output logic                          half_full,
    output logic                          almostempty,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'(FIFO_DEPTH / 2);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    // Refuse to build with a geometry the pointer arithmetic cannot support
    // or thresholds that would make the almost flags meaningless.
    generate
        if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_param_sync: FIFO_DEPTH must be a power of two >= 4");
        end
        if (FIFO_WIDTH < 1) begin : g_bad_width
            $error("fifo_param_sync: FIFO_WIDTH must be >= 1");
        end
        if (AE_THRESH < 1 || AE_THRESH >= AF_THRESH || AF_THRESH > FIFO_DEPTH - 1) begin : g_bad_thresh
            $error("fifo_param_sync: need 1 <= AE_THRESH < AF_THRESH <= FIFO_DEPTH-1");
        end
    endgenerate

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [FIFO_WIDTH-1:0] rd_word_p1;
    logic [FIFO_WIDTH-1:0] fwft_word;
    logic                  wr_accept;
    logic                  rd_accept;

    // Acceptance is decided on the registered count, so the request inputs
    // never reach an output without passing through a flop.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // Status flags: all decoded from the registered count
    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign half_full   = (count >= HALF_C);
    assign almostfull  = (count >= AF_C) && !full;
    assign almostempty = (count <= AE_C) && !empty;

    // Storage has no reset; stale words are never visible because every
    // read path is qualified by count.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Control, pointers, count and registered read word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_word_p1 <= '0;
            wr_ack     <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ack    <= wr_accept;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;

            // Power-of-two depth: natural binary wrap is modulo FIFO_DEPTH.
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (FWFT == 0) begin
                    rd_word_p1 <= mem[rd_ptr];
                end
            end

            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Fall-through view: head of queue whenever something is stored.
    assign fwft_word = empty ? '0 : mem[rd_ptr];
    assign data_out  = (FWFT != 0) ? fwft_word : rd_word_p1;

endmodule

// File: tb/tb_fifo_param_sync.sv
// Testbench for fifo_param_sync. Two instances share one stimulus stream:
// dut0 uses the default parameters (registered read), dut1 uses FWFT with
// AF_THRESH=5 and AE_THRESH=2. A queue-based reference model tracks the
// stored words; a monitor on the falling edge compares every output.
module tb_fifo_param_sync;

    localparam int W = 16;
    localparam int D = 8;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  data_in;
    logic          wr_en;
    logic          rd_en;

    logic [W-1:0]  dout0, dout1;
    logic          ack0, ack1, ovf0, ovf1, udf0, udf1;
    logic [3:0]    cnt0, cnt1;
    logic          full0, full1, af0, af1, hf0, hf1, ae0, ae1, emp0, emp1;

    int n_chk;
    int n_fail;

    // Reference model state
    logic [W-1:0] mq[$];        // stored words, head at index 0
    logic [W-1:0] rd_exp_q[$];  // words expected on dut0.data_out
    logic         e_ack, e_ovf, e_udf;
    logic [W-1:0] held;         // value dut0.data_out should be holding

    fifo_param_sync #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_THRESH(D-1), .AE_THRESH(1), .FWFT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(dout0), .wr_ack(ack0), .overflow(ovf0), .underflow(udf0),
        .count(cnt0), .full(full0), .almostfull(af0), .half_full(hf0),
        .almostempty(ae0), .empty(emp0)
    );

    fifo_param_sync #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_THRESH(5), .AE_THRESH(2), .FWFT(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(dout1), .wr_ack(ack1), .overflow(ovf1), .underflow(udf1),
        .count(cnt1), .full(full1), .almostfull(af1), .half_full(hf1),
        .almostempty(ae1), .empty(emp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on the same edge as the DUT, from the
    // request inputs and its own queue only.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            rd_exp_q.delete();
            e_ack = 1'b0;
            e_ovf = 1'b0;
            e_udf = 1'b0;
        end else begin
            bit wa;
            bit ra;
            wa = wr_en && (mq.size() < D);
            ra = rd_en && (mq.size() > 0);
            e_ack = wa;
            e_ovf = wr_en && (mq.size() == D);
            e_udf = rd_en && (mq.size() == 0);
            if (ra) rd_exp_q.push_back(mq.pop_front());
            if (wa) mq.push_back(data_in);
        end
    end

    // Monitor: compare everything on the falling edge.
    always @(negedge clk) begin
        int c;
        c = mq.size();
        if (!rst_n) held = '0;
        // A read accepted on the last edge presents its word now.
        if (rd_exp_q.size() > 0) held = rd_exp_q.pop_front();
        chk("dout0",     32'(dout0), 32'(held));
        chk("count0",    32'(cnt0),  32'(c));
        chk("empty0",    32'(emp0),  32'(c == 0));
        chk("full0",     32'(full0), 32'(c == D));
        chk("half0",     32'(hf0),   32'(c >= D/2));
        chk("afull0",    32'(af0),   32'(c >= 7 && c != D));
        chk("aempty0",   32'(ae0),   32'(c <= 1 && c != 0));
        chk("wr_ack0",   32'(ack0),  32'(e_ack));
        chk("ovf0",      32'(ovf0),  32'(e_ovf));
        chk("udf0",      32'(udf0),  32'(e_udf));
        chk("dout1",     32'(dout1), (c == 0) ? 32'd0 : 32'(mq[0]));
        chk("count1",    32'(cnt1),  32'(c));
        chk("afull1",    32'(af1),   32'(c >= 5 && c != D));
        chk("aempty1",   32'(ae1),   32'(c <= 2 && c != 0));
        chk("flags1",    {28'd0, full1, emp1, hf1, ack1}, {28'd0, c == D, c == 0, c >= D/2, e_ack});
        chk("strobes1",  {30'd0, ovf1, udf1}, {30'd0, e_ovf, e_udf});
    end

    task automatic cyc(input logic w, input logic r, input logic [W-1:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        held    = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        repeat (3) cyc(1'b0, 1'b0, '0);

        // Fill 1..8, then a ninth write that must overflow
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, W'(i));
        cyc(1'b1, 1'b0, 16'h00FF);
        cyc(1'b0, 1'b0, '0);

        // Drain all eight, then one read that must underflow
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);

        // Simultaneous read/write at full, empty and mid-occupancy
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'h1100 + W'(i));
        cyc(1'b1, 1'b1, 16'hDEAD);               // full: 8 -> 7, overflow
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, 16'h2222);               // empty: 0 -> 1, underflow + ack
        cyc(1'b1, 1'b0, 16'h3333);
        cyc(1'b1, 1'b0, 16'h4444);
        cyc(1'b1, 1'b1, 16'h5555);               // count 3 stays 3
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);

        // Fall-through visibility, thresholds of the second instance
        cyc(1'b1, 1'b0, 16'hA5A5);
        cyc(1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'hB000 + W'(i));
        cyc(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);

        // Asynchronous reset in the middle of a write burst at count 5
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'hC000 + W'(i));
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", 32'(cnt0), 32'd0);
        chk("async_empty", {30'd0, emp0, emp1}, 32'd3);
        chk("async_dout",  {dout0, dout1}, 32'd0);
        chk("async_strb",  {26'd0, ack0, ovf0, udf0, ack1, ovf1, udf1}, 32'd0);
        chk("async_flags", {24'd0, full0, af0, hf0, ae0, full1, af1, hf1, ae1}, 32'd0);
        wr_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 1'b0, 16'h1234);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);

        // Randomised traffic: write-heavy, read-heavy, then balanced
        for (int ph = 0; ph < 3; ph++) begin
            int pw;
            int pr;
            pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
            pr = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
            for (int i = 0; i < 150; i++) begin
                cyc(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), W'($urandom));
            end
        end
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
